// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encodings, requester indices,
// the default byte width and the owner-selection helper.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam logic REQ0     = 1'b0;
    localparam logic REQ1     = 1'b1;
    localparam int   DBIT_DEF = 8;

    // A lone requester wins outright; on contention the round-robin pointer decides.
    function automatic logic pick_owner(input logic v0, input logic v1, input logic rr_ptr);
        if (v0 && v1)
            return rr_ptr;
        else if (v1)
            return REQ1;
        else
            return REQ0;
    endfunction

endpackage

// File: rtl/arb_idle_timer.sv
// Idle-owner timer for uart_tx_arbiter: counts stalled-owner cycles and flags the terminal count.
// Compiled only when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_idle_timer #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int TCNT_W      = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam logic [TCNT_W-1:0] TERM_CNT = TCNT_W'(TIMEOUT_CYC - 1);

    logic [TCNT_W-1:0] cnt;

    assign expire = tick && (cnt == TERM_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear || expire)
            cnt <= '0;
        else if (tick)
            cnt <= cnt + 1'b1;
    end

endmodule
`endif

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port between two requesters.
// Define ARB_TIMEOUT_EN to force release of an owner that stays idle for TIMEOUT_CYC cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DBIT        = DBIT_DEF,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TCNT_W      = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0_valid,
    input  logic [DBIT-1:0] req0_data,
    input  logic            req0_last,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [DBIT-1:0] req1_data,
    input  logic            req1_last,
    output logic            req1_ready,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [1:0]      grant,
    output logic            busy,
    output logic            timeout_evt
);

    if ((1 << TCNT_W) < TIMEOUT_CYC) begin : g_cfg_err
        $error("TCNT_W too narrow to reach TIMEOUT_CYC");
    end

    arb_state_t      state;
    logic            own;
    logic            rr_ptr;
    logic            own_valid;
    logic            own_last;
    logic [DBIT-1:0] own_data;
    logic            xfer;
    logic            expire;

    assign own_valid = own ? req1_valid : req0_valid;
    assign own_last  = own ? req1_last  : req0_last;
    assign own_data  = own ? req1_data  : req0_data;

    // A byte moves only while locked, the owner offers one and the FIFO has room.
    assign xfer       = (state == ARB_LOCK) && own_valid && !tx_full;
    assign wr_uart    = xfer;
    assign req0_ready = xfer && (own == REQ0);
    assign req1_ready = xfer && (own == REQ1);
    assign w_data     = (state == ARB_LOCK) ? own_data : '0;

    assign busy  = (state == ARB_LOCK);
    assign grant = (state != ARB_LOCK) ? 2'b00 : (own ? 2'b10 : 2'b01);

`ifdef ARB_TIMEOUT_EN
    logic timeout_q;

    // Stalls on tx_full keep the owner valid, so only a silent owner advances the timer.
    arb_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TCNT_W      (TCNT_W)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   ((state != ARB_LOCK) || xfer),
        .tick    ((state == ARB_LOCK) && !own_valid),
        .expire  (expire)
    );

    assign timeout_evt = timeout_q;
`else
    assign expire      = 1'b0;
    assign timeout_evt = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ARB_IDLE;
            own    <= REQ0;
            rr_ptr <= REQ0;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        state <= ARB_LOCK;
                        own   <= pick_owner(req0_valid, req1_valid, rr_ptr);
                    end
                end
                ARB_LOCK: begin
                    // The requester just served drops to low priority for the next contention.
                    if (xfer && own_last) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= ~own;
                    end else if (expire) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= ~own;
`ifdef ARB_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = '0;
    logic       req0_last = 1'b0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = '0;
    logic       req1_last = 1'b0;
    logic       req1_ready;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_evt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DBIT        (8),
        .TIMEOUT_CYC (16),
        .TCNT_W      (10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_last   (req0_last),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_last   (req1_last),
        .req1_ready  (req1_ready),
        .tx_full     (tx_full),
        .wr_uart     (wr_uart),
        .w_data      (w_data),
        .grant       (grant),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge and checked 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [7:0] d, input logic l);
        req0_valid = v;
        req0_data  = d;
        req0_last  = l;
    endtask

    task automatic drv1(input logic v, input logic [7:0] d, input logic l);
        req1_valid = v;
        req1_data  = d;
        req1_last  = l;
    endtask

    task automatic do_reset();
        drv0(1'b0, 8'h00, 1'b0);
        drv1(1'b0, 8'h00, 1'b0);
        tx_full = 1'b0;
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic chk_wr(input string tag, input logic [7:0] d);
        chk({tag, "_wr"}, wr_uart, 1);
        chk({tag, "_data"}, w_data, d);
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_wr", wr_uart, 0);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_evt", timeout_evt, 0);

        // 1: three-byte packet from req0
        cyc();
        drv0(1'b1, 8'h41, 1'b0);
        #1;
        chk("t1_idle_grant", grant, 2'b00);
        chk("t1_idle_wr", wr_uart, 0);
        chk("t1_idle_rdy0", req0_ready, 0);
        cyc();
        #1;
        chk("t1_grant", grant, 2'b01);
        chk("t1_busy", busy, 1);
        chk("t1_rdy0", req0_ready, 1);
        chk_wr("t1_b0", 8'h41);
        cyc();
        drv0(1'b1, 8'h42, 1'b0);
        #1;
        chk_wr("t1_b1", 8'h42);
        cyc();
        drv0(1'b1, 8'h0A, 1'b1);
        #1;
        chk_wr("t1_b2", 8'h0A);
        cyc();
        drv0(1'b0, 8'h00, 1'b0);
        #1;
        chk("t1_end_grant", grant, 2'b00);
        chk("t1_end_busy", busy, 0);

        // 2: simultaneous requests after reset, then fairness on next contention
        do_reset();
        drv0(1'b1, 8'hA0, 1'b0);
        drv1(1'b1, 8'hB0, 1'b1);
        #1;
        chk("t2_idle_grant", grant, 2'b00);
        cyc();
        #1;
        chk("t2_grant0", grant, 2'b01);
        chk("t2_rdy1_blk", req1_ready, 0);
        chk_wr("t2_a0", 8'hA0);
        cyc();
        drv0(1'b1, 8'hA1, 1'b1);
        #1;
        chk_wr("t2_a1", 8'hA1);
        cyc();
        drv0(1'b0, 8'h00, 1'b0);
        #1;
        chk("t2_gap_grant", grant, 2'b00);
        chk("t2_gap_wr", wr_uart, 0);
        cyc();
        #1;
        chk("t2_grant1", grant, 2'b10);
        chk("t2_rdy1", req1_ready, 1);
        chk_wr("t2_b0", 8'hB0);
        cyc();
        drv1(1'b1, 8'hD0, 1'b1);
        drv0(1'b1, 8'hC0, 1'b1);
        #1;
        chk("t2_gap2_grant", grant, 2'b00);
        cyc();
        #1;
        chk("t2_rr_grant", grant, 2'b01);
        chk_wr("t2_c0", 8'hC0);
        cyc();
        drv0(1'b0, 8'h00, 1'b0);
        cyc();
        #1;
        chk("t2_rr_grant1", grant, 2'b10);
        chk_wr("t2_d0", 8'hD0);
        cyc();
        drv1(1'b0, 8'h00, 1'b0);

        // 3: req1 owns the port while the FIFO is full for 5 cycles
        cyc();
        drv1(1'b1, 8'h51, 1'b0);
        cyc();
        #1;
        chk("t3_grant", grant, 2'b10);
        chk_wr("t3_b0", 8'h51);
        cyc();
        drv1(1'b1, 8'h52, 1'b0);
        drv0(1'b1, 8'h61, 1'b1);
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_full_wr", wr_uart, 0);
            chk("t3_full_rdy1", req1_ready, 0);
            chk("t3_full_rdy0", req0_ready, 0);
            chk("t3_full_grant", grant, 2'b10);
            cyc();
        end
        tx_full = 1'b0;
        #1;
        chk_wr("t3_b1", 8'h52);
        chk("t3_rdy0_blk", req0_ready, 0);
        cyc();
        drv1(1'b1, 8'h53, 1'b1);
        #1;
        chk_wr("t3_b2", 8'h53);
        cyc();
        drv1(1'b0, 8'h00, 1'b0);
        #1;
        chk("t3_gap_grant", grant, 2'b00);
        cyc();
        #1;
        chk("t3_next_grant", grant, 2'b01);
        chk_wr("t3_r0", 8'h61);
        cyc();
        drv0(1'b0, 8'h00, 1'b0);

        // 4: reset mid-packet while req0 would otherwise be low priority
        cyc();
        drv0(1'b1, 8'h71, 1'b0);
        cyc();
        #1;
        chk_wr("t4_b0", 8'h71);
        cyc();
        drv0(1'b1, 8'h72, 1'b0);
        #1;
        chk_wr("t4_b1_pre", 8'h72);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_grant", grant, 2'b00);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_wr", wr_uart, 0);
        chk("t4_rst_rdy0", req0_ready, 0);
        drv0(1'b0, 8'h00, 1'b0);
        cyc();
        reset_n = 1'b1;
        cyc();
        drv0(1'b1, 8'h81, 1'b1);
        drv1(1'b1, 8'h91, 1'b1);
        cyc();
        #1;
        chk("t4_post_grant", grant, 2'b01);
        chk_wr("t4_post_b", 8'h81);
        cyc();
        drv0(1'b0, 8'h00, 1'b0);
        cyc();
        #1;
        chk("t4_post_grant1", grant, 2'b10);
        chk_wr("t4_post_r1", 8'h91);
        cyc();
        drv1(1'b0, 8'h00, 1'b0);

        // 5/6: owner goes silent mid-packet with req1 waiting
        cyc();
        drv0(1'b1, 8'hE0, 1'b0);
        cyc();
        #1;
        chk("t5_grant", grant, 2'b01);
        chk_wr("t5_b0", 8'hE0);
        cyc();
        drv0(1'b0, 8'h00, 1'b0);
        drv1(1'b1, 8'hF0, 1'b1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t5_hold_grant", grant, 2'b01);
            chk("t5_hold_evt", timeout_evt, 0);
            chk("t5_hold_wr", wr_uart, 0);
            cyc();
        end
        #1;
        chk("t5_evt", timeout_evt, 1);
        chk("t5_rel_grant", grant, 2'b00);
        cyc();
        #1;
        chk("t5_evt_off", timeout_evt, 0);
        chk("t5_next_grant", grant, 2'b10);
        chk_wr("t5_f0", 8'hF0);
        cyc();
        drv1(1'b0, 8'h00, 1'b0);
`else
        for (int i = 0; i < 40; i++) begin
            #1;
            chk("t6_hold_grant", grant, 2'b01);
            chk("t6_hold_evt", timeout_evt, 0);
            chk("t6_hold_rdy1", req1_ready, 0);
            cyc();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
